// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the load/store unit and the memory.
//   mem_req   : request active (held until mem_ready)
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned address
//   mem_be    : byte enables, already shifted into lane position
//   mem_wdata : write data, already shifted into lane position
//   mem_ready : memory completes the request this cycle
//   mem_rdata : read data, valid with mem_ready
interface lsu_mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store unit: takes decoded memory controls plus ALU address and rs2
// data, performs one handshaked data-memory access with wait states and an
// abort timeout, and returns aligned, extended load data to writeback.
//   clk, rst      : clock, synchronous active-high reset
//   acc_valid     : decoded instruction valid this cycle
//   rwmem, memWE  : memory access / store select from the decoder
//   byteena       : unshifted store lane mask
//   funct3        : access width and signedness
//   addr, wdata   : effective address, store data
//   stall         : hold PC/pipeline while an access is in flight
//   done          : one-cycle completion pulse
//   load_data     : extended load result (valid with done && !err)
//   load_we       : register write strobe for load_data
//   err, err_code : 1 misaligned, 2 illegal funct3/byteena, 3 timeout
//   mem           : data-memory bus (master side)
module lsu_mem_access #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acc_valid,
    input  logic            rwmem,
    input  logic            memWE,
    input  logic [3:0]      byteena,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            load_we,
    output logic            err,
    output logic [1:0]      err_code,
    lsu_mem_access_if.master mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_we;

    logic        start;
    logic        illegal;
    logic        misaligned;
    logic [31:0] shifted;
    logic [31:0] extracted;

    always_comb begin
        start      = (state == IDLE) && acc_valid && rwmem;
        stall      = start || (state == REQ);
        illegal    = memWE ? ((funct3 > 3'd2) || (byteena == 4'b0000))
                           : ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
        // funct3[1:0] gives the access size for both loads and stores.
        misaligned = ((funct3[1:0] == 2'd1) && addr[0]) ||
                     ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        shifted   = mem.mem_rdata >> {r_off, 3'b000};
        extracted = '0;
        case (r_f3)
            3'd0:    extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    extracted = shifted;
            3'd4:    extracted = {24'b0, shifted[7:0]};
            3'd5:    extracted = {16'b0, shifted[15:0]};
            default: extracted = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            r_off         <= '0;
            r_f3          <= '0;
            r_we          <= 1'b0;
            done          <= 1'b0;
            load_data     <= '0;
            load_we       <= 1'b0;
            err           <= 1'b0;
            err_code      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r_off <= addr[1:0];
                        r_f3  <= funct3;
                        r_we  <= memWE;
                        cnt   <= '0;
                        if (illegal) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else if (misaligned) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end else begin
                            state         <= REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= memWE;
                            mem.mem_addr  <= {addr[31:2], 2'b00};
                            mem.mem_be    <= memWE ? (byteena << addr[1:0]) : 4'b1111;
                            mem.mem_wdata <= wdata << {addr[1:0], 3'b000};
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready || (cnt == 8'(TIMEOUT - 1))) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= '0;
                        mem.mem_be    <= '0;
                        mem.mem_wdata <= '0;
                        if (mem.mem_ready) begin
                            if (!r_we) begin
                                load_data <= extracted;
                                load_we   <= 1'b1;
                            end
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    load_data <= '0;
                    load_we   <= 1'b0;
                    err       <= 1'b0;
                    err_code  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_valid;
    logic        rwmem;
    logic        memWE;
    logic [3:0]  byteena;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        load_we;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    lsu_mem_access_if mif ();

    lsu_mem_access #(.TIMEOUT(TO), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .rwmem     (rwmem),
        .memWE     (memWE),
        .byteena   (byteena),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .load_data (load_data),
        .load_we   (load_we),
        .err       (err),
        .err_code  (err_code),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: error classification from the access rules.
    function automatic int exp_code_of(input bit we, input logic [3:0] be,
                                       input int f3, input logic [31:0] a, input int waits);
        int nbytes;
        if (we && (f3 > 2 || be == 0)) return 2;
        if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 2;
        nbytes = 1 << (f3 % 4);
        if (a % nbytes != 0) return 1;
        if (waits >= int'(TO)) return 3;
        return 0;
    endfunction

    // Reference: load result by arithmetic on the selected bytes.
    function automatic logic [31:0] exp_load(input int f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd / (32'd1 << (8 * (a % 4)));
        case (f3)
            0: begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
            1: begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
            2: ;
            4: v = v % 256;
            5: v = v % 65536;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic do_access(input bit we, input logic [3:0] be, input int f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int waits);
        int code;
        int off;
        code = exp_code_of(we, be, f3, a, waits);
        off  = int'(a % 4);
        @(negedge clk);
        acc_valid = 1'b1; rwmem = 1'b1; memWE = we; byteena = be;
        funct3 = 3'(f3); addr = a; wdata = wd; mif.mem_ready = 1'b0;
        #1;
        chk("stall_start", {31'b0, stall}, 32'd1);
        chk("req_before", {31'b0, mif.mem_req}, 32'd0);
        @(negedge clk);
        acc_valid = 1'b0; rwmem = 1'b0; addr = $urandom; wdata = $urandom;
        if (code == 0 || code == 3) begin
            for (int k = 0; k < int'(TO); k++) begin
                chk("req", {31'b0, mif.mem_req}, 32'd1);
                chk("stall_req", {31'b0, stall}, 32'd1);
                chk("done_req", {31'b0, done}, 32'd0);
                chk("mem_we", {31'b0, mif.mem_we}, {31'b0, we});
                chk("mem_addr", mif.mem_addr, a - (a % 4));
                chk("mem_be", {28'b0, mif.mem_be},
                    we ? (32'(be) * (32'd1 << off)) % 16 : 32'd15);
                if (we) chk("mem_wdata", mif.mem_wdata, wd * (32'd1 << (8 * off)));
                mif.mem_ready = (k == waits);
                mif.mem_rdata = (k == waits) ? rd : $urandom;
                @(negedge clk);
                if (k == waits) break;
            end
            mif.mem_ready = 1'b0;
        end
        chk("done", {31'b0, done}, 32'd1);
        chk("err", {31'b0, err}, (code != 0) ? 32'd1 : 32'd0);
        chk("err_code", {30'b0, err_code}, 32'(code));
        chk("req_done", {31'b0, mif.mem_req}, 32'd0);
        chk("stall_done", {31'b0, stall}, 32'd0);
        chk("load_we", {31'b0, load_we}, (!we && code == 0) ? 32'd1 : 32'd0);
        chk("load_data", load_data, (!we && code == 0) ? exp_load(f3, a, rd) : 32'd0);
        // A late response outside the request phase must be ignored.
        mif.mem_ready = 1'b1; mif.mem_rdata = $urandom;
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("req_idle", {31'b0, mif.mem_req}, 32'd0);
        chk("stall_idle", {31'b0, stall}, 32'd0);
        mif.mem_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] bes [4];
        bes[0] = 4'b0001; bes[1] = 4'b0011; bes[2] = 4'b1111; bes[3] = 4'b0000;
        rst = 1'b1; acc_valid = 1'b0; rwmem = 1'b0; memWE = 1'b0;
        byteena = '0; funct3 = '0; addr = '0; wdata = '0;
        mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, mif.mem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_err", {30'b0, err_code}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        rst = 1'b0;

        do_access(1'b0, 4'b1111, 2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        do_access(1'b0, 4'b0001, 0, 32'h103, 32'h0, 32'h80112233, 1);
        do_access(1'b0, 4'b0001, 4, 32'h103, 32'h0, 32'h80112233, 2);
        do_access(1'b1, 4'b0011, 1, 32'h102, 32'h0000ABCD, 32'h0, 0);
        do_access(1'b0, 4'b1111, 2, 32'h101, 32'h0, 32'h0, 0);
        do_access(1'b0, 4'b1111, 3, 32'h100, 32'h0, 32'h0, 0);
        do_access(1'b0, 4'b1111, 2, 32'h200, 32'h0, 32'h12345678, 99);

        // Reset in the middle of a request.
        @(negedge clk);
        acc_valid = 1'b1; rwmem = 1'b1; memWE = 1'b0; funct3 = 3'd2; addr = 32'h300;
        @(negedge clk);
        acc_valid = 1'b0; rwmem = 1'b0;
        chk("rq_before_rst", {31'b0, mif.mem_req}, 32'd1);
        rst = 1'b1; mif.mem_ready = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b0; mif.mem_ready = 1'b0;
        chk("rst_mid_req", {31'b0, mif.mem_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        do_access(1'b0, 4'b1111, 5, 32'h302, 32'h0, 32'h8001FFFF, 1);

        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), bes[$urandom_range(0, 3)],
                      int'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
